// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory responder: access size encodings,
// FSM states, default geometry and small alignment helpers.
package data_mem_pkg;

  localparam int unsigned DEFAULT_DEPTH       = 32;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  // funct3-style access size; SZ_BAD is the one unused code point
  typedef enum logic [2:0] {
    SZ_B   = 3'b000,
    SZ_H   = 3'b001,
    SZ_W   = 3'b010,
    SZ_D   = 3'b011,
    SZ_BU  = 3'b100,
    SZ_HU  = 3'b101,
    SZ_WU  = 3'b110,
    SZ_BAD = 3'b111
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] lane);
    case (size[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      2'b10:   return |lane[1:0];
      default: return |lane;
    endcase
  endfunction

  // Byte enables before shifting to the addressed lane
  function automatic logic [7:0] size_bytes(input logic [2:0] size);
    case (size[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane extraction with sign/zero extension for loads, and byte-merge of
// right-justified store data into the existing doubleword.
module load_store_align
  import data_mem_pkg::*;
(
  input  logic [2:0]  lane,
  input  logic [2:0]  size,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_word
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [63:0] mask;
  logic [7:0]  be;

  always_comb begin
    shifted   = word >> {lane, 3'b000};
    load_data = shifted;
    case (size_e'(size))
      SZ_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      SZ_BU:   load_data = {56'd0, shifted[7:0]};
      SZ_HU:   load_data = {48'd0, shifted[15:0]};
      SZ_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    be     = size_bytes(size) << lane;
    mask   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    wshift     = wdata << {lane, 3'b000};
    store_word = (word & ~mask) | (wshift & mask);
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a small doubleword memory,
// with a configurable number of wait states before each access commits.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [2:0]  lat_size;
  logic [63:0] mem [DEPTH];

  logic             accept;
  logic             commit;
  logic             cur_write;
  logic [63:0]      cur_addr;
  logic [63:0]      cur_wdata;
  logic [2:0]       cur_size;
  logic             in_range;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic [63:0]      rd_word;
  logic [63:0]      load_data;
  logic [63:0]      store_word;

  // With no wait states the access commits on the accept edge itself, so the
  // live request is used instead of the (not yet loaded) latched copy.
  always_comb begin
    accept = (state == IDLE) && req_valid && req_ready;
    commit = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));
    if (state == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_size  = req_size;
    end else begin
      cur_write = lat_write;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_size  = lat_size;
    end
  end

  always_comb begin
    in_range = {3'b000, cur_addr[63:3]} < 64'(DEPTH);
    idx      = cur_addr[IDX_W+2:3];
    rd_word  = in_range ? mem[idx] : '0;
    err      = misaligned(cur_size, cur_addr[2:0]) || !in_range ||
               (cur_size == SZ_BAD) || (cur_write && cur_size[2]);
  end

  load_store_align u_align (
    .lane       (cur_addr[2:0]),
    .size       (cur_size),
    .word       (rd_word),
    .wdata      (cur_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else if (commit && cur_write && !err) begin
      mem[idx] <= store_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_size  <= req_size;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= err;
              rsp_rdata <= (err || cur_write) ? '0 : load_data;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= err;
            rsp_rdata <= (err || cur_write) ? '0 : load_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Ready rises on the handshake edge, so the next accept is one cycle later
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of 64-bit doublewords stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between request accept and memory commit (range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: core presents a load/store request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 64 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 64 bits: store data, right-justified.
REQ-010 SHALL have port req_size, input, 3 bits: funct3 encoding (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu).
REQ-011 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: core accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 64 bits: load result, extended per req_size; 0 for stores and errors.
REQ-014 SHALL have port rsp_error, output, 1 bit: request was misaligned, out of range or illegal size.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on an edge where req_valid && req_ready, and latch write, addr, wdata, size.
REQ-019 SHALL leave IDLE after accept: go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-020 SHALL stay in WAIT exactly WAIT_CYCLES cycles using a down-counter, then go to RESP.
REQ-021 SHALL commit stores and capture load data on the edge entering RESP, so rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 SHALL, in RESP, hold rsp_valid, rsp_rdata and rsp_error stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-023 SHALL NOT accept a new request in the cycle its response handshake completes; the earliest next accept is one cycle later.
REQ-024 SHALL use word index addr[63:3] and byte lane addr[2:0], little-endian.
REQ-025 SHALL, for loads, extract the lane, then sign-extend (b/h/w) or zero-extend (bu/hu/wu); d returns the full doubleword.
REQ-026 SHALL, for stores, merge only the addressed bytes (sb 1, sh 2, sw 4, sd 8) and leave the other bytes unchanged.
REQ-027 SHALL flag rsp_error when addr is not size-aligned, addr[63:3] >= DEPTH, size is 111, or a store uses size 1xx.
REQ-028 SHALL, on error, not modify memory and return rsp_rdata=0.
REQ-029 SHALL ignore req_valid and request inputs outside IDLE.

Reset
REQ-030 SHALL, while reset=0, force state IDLE, clear the wait counter and latched request, set req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, and clear all memory words to 0.
REQ-031 SHALL drive req_ready=1 in the first cycle after reset deasserts.
REQ-032 SHALL abandon a transaction on reset mid-operation; a store not yet committed leaves no effect.

Structure
REQ-033 SHALL take size encodings, the state enumeration and the default DEPTH and WAIT_CYCLES from shared package data_mem_pkg.
REQ-034 SHALL place lane extract, extension and store byte-merge in one combinational sub-module, load_store_align.

Verification
REQ-035 SHALL check reset release followed by sd 0x1122334455667788 at addr 0x8, then ld at 0x8 -> rdata 0x1122334455667788, rsp_error 0, rsp_valid 3 cycles after each accept.
REQ-036 SHALL check sb 0x80 at addr 0xB, then lb at 0xB -> 0xFFFFFFFFFFFFFF80 and lbu at 0xB -> 0x80; ld at 0x8 -> 0x1122334480667788.
REQ-037 SHALL check lw at 0x6 -> rsp_error 1 and rdata 0; sd at DEPTH*8 -> rsp_error 1 and memory unchanged.
REQ-038 SHALL check a response held with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0, and a competing req_valid ignored.
REQ-039 SHALL check reset asserted one cycle after an sd accept at 0x10 -> ld at 0x10 after release returns 0.
REQ-040 SHALL check WAIT_CYCLES=0 with back-to-back requests and rsp_ready tied high -> one transaction every 2 cycles, latency 1.
